// File: rtl/coin_feeder_if.sv
// Coin-insert bus between a batch requester and the coin feeder.
// The requester also returns the coffee machine's Mealy coffee output.
interface coin_feeder_if;
  logic       start;
  logic [3:0] cnt10;
  logic [3:0] cnt01;
  logic       coffee;
  logic       insert;
  logic [1:0] coins;
  logic       busy;
  logic       done;
  logic [4:0] coffee_count;

  modport master (
    output start, cnt10, cnt01, coffee,
    input  insert, coins, busy, done, coffee_count
  );

  modport slave (
    input  start, cnt10, cnt01, coffee,
    output insert, coins, busy, done, coffee_count
  );
endinterface

// File: rtl/coin_feeder.sv
// Replays a batch of code-10 then code-01 coins as clean insert pulses
// to the coffee machine and counts the coffees it hands back.
module coin_feeder #(
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 2
) (
  input  logic          clk,
  input  logic          reset,
  coin_feeder_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_GAP,
    S_DONE
  } state_t;

  localparam int MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int PW      = $clog2(MAX_CYC + 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [PW-1:0] GAP_LAST   = PW'(GAP_CYCLES - 1);

  state_t        state_reg,  state_next;
  logic [PW-1:0] phase_reg,  phase_next;
  logic [3:0]    r10_reg,    r10_next;
  logic [3:0]    r01_reg,    r01_next;
  logic          send10_reg, send10_next;
  logic          insert_reg, insert_next;
  logic [1:0]    coins_reg,  coins_next;
  logic          busy_reg,   busy_next;
  logic          done_reg,   done_next;
  logic [4:0]    count_reg,  count_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      phase_reg  <= '0;
      r10_reg    <= '0;
      r01_reg    <= '0;
      send10_reg <= 1'b0;
      insert_reg <= 1'b0;
      coins_reg  <= 2'b00;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      phase_reg  <= phase_next;
      r10_reg    <= r10_next;
      r01_reg    <= r01_next;
      send10_reg <= send10_next;
      insert_reg <= insert_next;
      coins_reg  <= coins_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      count_reg  <= count_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    phase_next  = phase_reg;
    r10_next    = r10_reg;
    r01_next    = r01_reg;
    send10_next = send10_reg;
    count_next  = count_reg;

    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          r10_next   = bus.cnt10;
          r01_next   = bus.cnt01;
          count_next = '0;
          state_next = (bus.cnt10 == 4'd0 && bus.cnt01 == 4'd0) ? S_DONE : S_SETUP;
        end
      end
      S_SETUP: begin
        send10_next = (r10_reg != 4'd0);
        phase_next  = '0;
        state_next  = S_HIGH;
      end
      S_HIGH: begin
        // The machine's Mealy coffee is only meaningful right after the insert edge.
        if (phase_reg == '0 && bus.coffee) begin
          count_next = count_reg + 5'd1;
        end
        if (phase_reg == PULSE_LAST) begin
          phase_next = '0;
          state_next = S_GAP;
          if (send10_reg) begin
            r10_next = r10_reg - 4'd1;
          end else begin
            r01_next = r01_reg - 4'd1;
          end
        end else begin
          phase_next = phase_reg + PW'(1);
        end
      end
      S_GAP: begin
        if (phase_reg == GAP_LAST) begin
          phase_next = '0;
          state_next = (r10_reg != 4'd0 || r01_reg != 4'd0) ? S_SETUP : S_DONE;
        end else begin
          phase_next = phase_reg + PW'(1);
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they are glitch-free at the machine.
  always_comb begin
    insert_next = (state_next == S_HIGH);
    busy_next   = (state_next == S_SETUP) || (state_next == S_HIGH) || (state_next == S_GAP);
    done_next   = (state_next == S_DONE);
    case (state_next)
      S_SETUP: coins_next = (r10_next != 4'd0) ? 2'b10 : 2'b01;
      S_HIGH:  coins_next = coins_reg;
      default: coins_next = 2'b00;
    endcase
  end

  assign bus.insert       = insert_reg;
  assign bus.coins        = coins_reg;
  assign bus.busy         = busy_reg;
  assign bus.done         = done_reg;
  assign bus.coffee_count = count_reg;

endmodule

// File: doc/coin_feeder.md
# coin_feeder

Transmitter-side driver for the coin-insert interface of the coffee machine FSM. It takes a batch request of N code-10 and M code-01 coins and replays them as clean `insert` pulses with stable `coins` values. It counts the `coffee` responses returned by the machine and reports batch completion with a one-cycle `done` pulse. It sits between the board controls or test sequencer and the coffee machine.

## Interface
- `PULSE_CYCLES`, default 2: cycles `insert` is held high per coin; must be ≥1.
- `GAP_CYCLES`, default 2: cycles `insert` is held low after each pulse; must be ≥1.
- `clk` input 1: clock; all logic is clocked on the rising edge.
- `reset` input 1: reset, synchronous, active-high.
- `start` input 1: batch request; sampled only in IDLE.
- `cnt10` input 4: number of code-10 coins (`coins=2'b10`) in the batch, 0-15.
- `cnt01` input 4: number of code-01 coins (`coins=2'b01`) in the batch, 0-15.
- `coffee` input 1: coffee output of the machine; a combinational Mealy output.
- `insert` output 1: registered insert strobe to the machine.
- `coins` output 2: registered coin code to the machine; 2'b00 when no coin is driven.
- `busy` output 1: high while a batch is in progress.
- `done` output 1: one-cycle pulse at batch end.
- `coffee_count` output 5: coffees counted in the current or last batch.

## Operation
- States: IDLE, SETUP, HIGH, GAP, DONE.
- **IDLE:** `busy`=0, `insert`=0, `coins`=00.
  - On `start`=1, latch `cnt10`/`cnt01` into remaining counters `r10`/`r01`.
  - On the same `start`, clear `coffee_count` and go to SETUP, or to DONE if both counts are 0.
- **Coin order:** all code-10 coins first, then all code-01 coins.
- **SETUP (1 cycle):**
  - `coins` = 2'b10 if `r10`≠0, else 2'b01.
  - `insert`=0.
  - This gives the machine one cycle of stable `coins` before the rising edge.
- **HIGH (PULSE_CYCLES cycles):**
  - `insert`=1; `coins` is held at the SETUP value.
  - In the first HIGH cycle only, if `coffee`=1, increment `coffee_count`.
  - The machine's Mealy output is only valid in the first cycle after the insert edge.
  - On leaving HIGH, decrement the counter of the coin just sent (`r10` or `r01`).
- **GAP (GAP_CYCLES cycles):**
  - `insert`=0, `coins`=00.
  - At the end, go to SETUP if `r10`+`r01`≠0, else DONE.
- **DONE (1 cycle):** `done`=1, `busy`=0, then IDLE.
- `busy`=1 in SETUP, HIGH and GAP.
- `coffee_count` holds its value after DONE until the next accepted `start`.
- `start` while not IDLE is ignored; no queuing.
- `coffee` outside the first HIGH cycle is ignored.
- `coffee_count` is 5 bits; the maximum batch is 30 coins, so it cannot overflow.
- A phase counter of width ≥ log2(max(PULSE_CYCLES, GAP_CYCLES)) times the HIGH and GAP phases.

## Timing
- **Reset values:** state IDLE; `insert`=0, `coins`=00, `busy`=0, `done`=0, `coffee_count`=0; `r10`=`r01`=0.
- **Reset mid-batch:** takes priority over every state, including HIGH. Outputs return to their reset values on the next edge. The batch is abandoned.
- **Start acceptance:** `start` is sampled at edge E0 in IDLE. `busy` and SETUP take effect from E0, i.e. the first cycle after E0.
- **Per-coin duration:** 1+PULSE_CYCLES+GAP_CYCLES cycles. With defaults, 5 cycles.
- **Batch duration:** for K=`cnt10`+`cnt01`>0 coins, `done` is high in cycle K·(1+P+G)+1 after E0.
- **Empty batch:** `done` is high in cycle 1 after E0; `busy` never rises.
- **First insert edge:** `insert` rises at E0+2 cycles.
- **Between coins:** consecutive insert rising edges are separated by exactly 1+P+G cycles.
- **Coin stability:** `coins` never changes while `insert`=1.
- **Coffee sampling:** `coffee` is sampled at the edge closing the first HIGH cycle.

## Test plan
- **Reset values:** assert `reset` for 2 cycles, then idle with `start`=0 → `insert`=0, `coins`=00, `busy`=0, `done`=0, `coffee_count`=0.
- **Two-coin batch with machine model:** defaults, `cnt10`=1, `cnt01`=1, machine model connected, start in IDLE →
  - `coins`=10 with `insert` high for cycles 2-3 after E0.
  - `coins`=01 with `insert` high for cycles 7-8 after E0.
  - `done` in cycle 11 after E0.
  - `coffee_count` matches the model's coffee pulses.
- **Empty batch:** `cnt10`=0, `cnt01`=0, `start` → `done` in cycle 1, `busy` stays 0, `coffee_count`=0.
- **Start while busy:** `start` pulsed again during HIGH of coin 1 in a 3-coin batch → ignored; exactly 3 insert pulses; a single `done`.
- **Coffee counted once per coin:** bench forces `coffee`=1 continuously, `cnt01`=4 → `coffee_count`=4, not 4·PULSE_CYCLES.
- **Reset mid-HIGH, then restart:** `reset` during HIGH → next cycle `insert`=0, `coins`=00, `busy`=0. A fresh `start` with `cnt10`=2 then completes normally: 2 pulses, `done` at cycle 11 after its E0.
